// File: rtl/ifm_line_feeder_if.sv
// rtl/ifm_line_feeder_if.sv - AXI-Stream pixel input bundle for ifm_line_feeder
interface ifm_line_feeder_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ifm_line_feeder.sv
// rtl/ifm_line_feeder.sv - 5-row circular line buffer sweeping 3x5 windows into the conv engine
// Optional framing check on s_axis.tlast enabled by FEEDER_TLAST_CHECK_EN.
module ifm_line_feeder #(
    parameter int IMG_W     = 50,
    parameter int IMG_H     = 50,
    parameter int ROW_WORDS = 13,
    parameter int SEND_GAP  = 8
) (
    input  logic                clk,
    input  logic                rstn,
    ifm_line_feeder_if.slave    s_axis,
    output logic [23:0]         o_pe_1_row,
    output logic [23:0]         o_pe_2_row,
    output logic [23:0]         o_pe_3_row,
    output logic [23:0]         o_pe_4_row,
    output logic [23:0]         o_pe_5_row,
    output logic                o_pe_valid,
    output logic                o_img_row_done,
    output logic                o_send_flg,
    output logic                o_busy,
    output logic                o_err
);
    localparam logic [3:0] WORD_LAST   = 4'(ROW_WORDS - 1);
    localparam logic [5:0] ROW_LAST    = 6'(IMG_H - 1);
    localparam logic [5:0] COL_LAST    = 6'(IMG_W - 3);
    localparam logic [5:0] PIX_COUNT   = 6'(IMG_W);
    localparam logic [3:0] STRIPE_LAST = 4'((IMG_H - 2) / 3 - 1);
    localparam logic [3:0] GAP_LAST    = 4'(SEND_GAP - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SWEEP, GAP, DONE} state_t;
    state_t state, nxt;

    logic [3:0]  word_cnt;
    logic [5:0]  row_cnt;
    logic [2:0]  fill_cnt;
    logic [3:0]  stripe_cnt;
    logic [5:0]  col_cnt;
    logic [3:0]  gap_cnt;
    logic [2:0]  wr_bank;
    logic [2:0]  base;
    logic        ready_q;
    logic        last_q;
    logic        done_q;
    logic [7:0]  line_mem [5][IMG_W];
    logic [5:0]  wr_idx [4];
    logic [2:0]  rd_bank [5];
    logic [23:0] win_row [5];

    logic beat, row_end, img_end, fill_end, col_end, gap_end, early_last;
    logic ready_nxt, win_en, last_win, done_en;

    function automatic logic [2:0] wrap5(input logic [3:0] v);
        return (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
    endfunction

    assign s_axis.tready = ready_q;
    assign beat     = s_axis.tvalid && ready_q;
    assign row_end  = word_cnt == WORD_LAST;
    assign img_end  = row_end && (row_cnt == ROW_LAST);
    // stripe 0 needs all five rows; later stripes reuse two overlap rows
    assign fill_end = row_end && (fill_cnt == ((stripe_cnt == 4'd0) ? 3'd4 : 3'd2));
    assign col_end  = col_cnt == COL_LAST;
    assign gap_end  = gap_cnt == GAP_LAST;

`ifdef FEEDER_TLAST_CHECK_EN
    assign early_last = beat && s_axis.tlast && !img_end;
`else
    logic unused_tlast;
    assign unused_tlast = s_axis.tlast;
    assign early_last   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (beat && !early_last) nxt = LOAD;
            LOAD:    if (early_last) nxt = IDLE;
                     else if (beat && fill_end) nxt = SWEEP;
            SWEEP:   if (col_end) nxt = (stripe_cnt == STRIPE_LAST) ? GAP : LOAD;
            GAP:     if (gap_end) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        ready_nxt = (nxt == IDLE) || (nxt == LOAD);
        win_en    = state == SWEEP;
        last_win  = (state == SWEEP) && col_end;
        done_en   = state == DONE;
    end

    always_comb begin
        for (int b = 0; b < 4; b++)
            wr_idx[b] = {word_cnt, 2'b00} + 6'(b);
        for (int k = 0; k < 5; k++) begin
            rd_bank[k] = wrap5({1'b0, base} + 4'(k));
            win_row[k] = {line_mem[rd_bank[k]][col_cnt],
                          line_mem[rd_bank[k]][col_cnt + 6'd1],
                          line_mem[rd_bank[k]][col_cnt + 6'd2]};
        end
    end

    // bytes past the last pixel of the row (padding in the final beat) are dropped
    always_ff @(posedge clk) begin
        if (beat) begin
            for (int b = 0; b < 4; b++)
                if (wr_idx[b] < PIX_COUNT)
                    line_mem[wr_bank][wr_idx[b]] <= s_axis.tdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            word_cnt   <= '0;
            row_cnt    <= '0;
            fill_cnt   <= '0;
            stripe_cnt <= '0;
            col_cnt    <= '0;
            gap_cnt    <= '0;
            wr_bank    <= '0;
            base       <= '0;
            ready_q    <= 1'b0;
        end else begin
            ready_q <= ready_nxt;
            if (early_last) begin
                word_cnt   <= '0;
                row_cnt    <= '0;
                fill_cnt   <= '0;
                stripe_cnt <= '0;
                wr_bank    <= '0;
                base       <= '0;
            end else if (beat) begin
                if (row_end) begin
                    word_cnt <= '0;
                    row_cnt  <= row_cnt + 6'd1;
                    wr_bank  <= wrap5({1'b0, wr_bank} + 4'd1);
                    fill_cnt <= fill_end ? 3'd0 : fill_cnt + 3'd1;
                end else begin
                    word_cnt <= word_cnt + 4'd1;
                end
            end
            if (state == SWEEP) begin
                if (col_end) begin
                    col_cnt    <= '0;
                    base       <= wrap5({1'b0, base} + 4'd3);
                    stripe_cnt <= stripe_cnt + 4'd1;
                end else begin
                    col_cnt <= col_cnt + 6'd1;
                end
            end
            gap_cnt <= (state == GAP) ? gap_cnt + 4'd1 : 4'd0;
            if (state == DONE) begin
                row_cnt    <= '0;
                stripe_cnt <= '0;
                wr_bank    <= '0;
                base       <= '0;
            end
        end
    end

    // windows and pulses leave one cycle after their SWEEP/DONE cycle; pulses take one more
    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_pe_1_row     <= '0;
            o_pe_2_row     <= '0;
            o_pe_3_row     <= '0;
            o_pe_4_row     <= '0;
            o_pe_5_row     <= '0;
            o_pe_valid     <= 1'b0;
            last_q         <= 1'b0;
            o_img_row_done <= 1'b0;
            done_q         <= 1'b0;
            o_send_flg     <= 1'b0;
            o_busy         <= 1'b0;
            o_err          <= 1'b0;
        end else begin
            o_pe_valid     <= win_en;
            last_q         <= last_win;
            o_img_row_done <= last_q;
            done_q         <= done_en;
            o_send_flg     <= done_q;
            if (win_en) begin
                o_pe_1_row <= win_row[0];
                o_pe_2_row <= win_row[1];
                o_pe_3_row <= win_row[2];
                o_pe_4_row <= win_row[3];
                o_pe_5_row <= win_row[4];
            end
            if (done_q || early_last) o_busy <= 1'b0;
            if (beat && (state == IDLE) && !early_last) o_busy <= 1'b1;
`ifdef FEEDER_TLAST_CHECK_EN
            if (beat && (s_axis.tlast != img_end)) o_err <= 1'b1;
`else
            o_err <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_ifm_line_feeder.sv
// tb/tb_ifm_line_feeder.sv - randomized scoreboard bench for ifm_line_feeder
module tb_ifm_line_feeder;
    localparam int W = 50, H = 50, RW = 13, NS = 16, WPS = 48;
    localparam int FINAL_BEAT = H * RW - 1;
`ifdef FEEDER_TLAST_CHECK_EN
    localparam bit TLAST_IGNORED = 1'b0;
`else
    localparam bit TLAST_IGNORED = 1'b1;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ifm_line_feeder_if axis();
    logic [23:0] r1, r2, r3, r4, r5;
    logic pe_valid, row_done, send_flg, busy, err;

    ifm_line_feeder dut (
        .clk(clk), .rstn(rstn), .s_axis(axis),
        .o_pe_1_row(r1), .o_pe_2_row(r2), .o_pe_3_row(r3), .o_pe_4_row(r4), .o_pe_5_row(r5),
        .o_pe_valid(pe_valid), .o_img_row_done(row_done), .o_send_flg(send_flg),
        .o_busy(busy), .o_err(err)
    );

    typedef struct {
        logic [119:0] win;
        int exp_cyc;
        int stripe;
        int col;
    } exp_t;

    exp_t exp_q[$];
    logic [7:0] img [H][W];
    int checks = 0, failures = 0;
    int cyc = 0;
    int sends = 0;
    int img_mode = 0;
    bit abort = 0;
    logic exp_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // expected windows for stripe s straight from the image: rows 3s..3s+4, columns c..c+2
    task automatic push_stripe(input int s, input int first_cyc);
        exp_t e;
        for (int c = 0; c < WPS; c++) begin
            e.win = '0;
            for (int k = 0; k < 5; k++)
                e.win = {e.win[95:0], img[3*s+k][c], img[3*s+k][c+1], img[3*s+k][c+2]};
            e.exp_cyc = (c == 0) ? first_cyc : -1;
            e.stripe  = s;
            e.col     = c;
            exp_q.push_back(e);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rows"}, {r1, r2, r3, r4, r5}, 120'h0);
        check({tag, "_flags"}, {pe_valid, row_done, send_flg, busy, err}, 5'b0);
        check({tag, "_tready"}, axis.tready, 1'b0);
    endtask

    task automatic pulse_reset();
        axis.tvalid = 1'b0;
        axis.tlast  = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        check_all_zero("mid_reset");
        @(negedge clk);
        rstn = 1'b1;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic run_image(input int mode, input bit gaps, input int reset_row,
                             input int early_beat, input bit drop_last);
        logic [31:0] d;
        int n, s0, bidx, idx;
        img_mode = mode;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = (mode == 0) ? 8'(r + c) : 8'($urandom);
        s0 = sends;
        for (int r = 0; r < H; r++) begin
            for (int w = 0; w < RW; w++) begin
                bidx = r * RW + w;
                if (r == reset_row && w == 0) begin
                    axis.tvalid = 1'b0;
                    repeat (10) @(negedge clk);
                    check("mid_sweep_before_reset", pe_valid, 1'b1);
                    pulse_reset();
                    return;
                end
                for (int b = 0; b < 4; b++) begin
                    idx = w * 4 + b;
                    d[8*b +: 8] = (idx < W) ? img[r][idx] : 8'($urandom);
                end
                while (gaps && $urandom_range(1, 0) == 1) begin
                    axis.tvalid = 1'b0;
                    axis.tdata  = $urandom;
                    @(negedge clk);
                end
                axis.tdata  = d;
                axis.tvalid = 1'b1;
                axis.tlast  = (bidx == FINAL_BEAT && !drop_last) || (bidx == early_beat) ||
                              (TLAST_IGNORED && gaps && bidx != FINAL_BEAT && $urandom_range(1, 0) == 1);
                n = 0;
                while (!axis.tready) begin
                    @(negedge clk);
                    n++;
                    if (n > 200) begin
                        check("handshake_timeout", 1'b0, 1'b1);
                        abort = 1;
                        return;
                    end
                end
                if (w == RW - 1 && r >= 4 && (r - 4) % 3 == 0)
                    push_stripe((r - 4) / 3, cyc + 2);
                @(negedge clk);
                if (bidx == early_beat) begin
                    axis.tvalid = 1'b0;
                    axis.tlast  = 1'b0;
                    check("early_tlast_err", err, 1'b1);
                    check("early_tlast_idle_ready", axis.tready, 1'b1);
                    check("early_tlast_busy", busy, 1'b0);
                    repeat (60) @(negedge clk);
                    check("early_tlast_no_windows", exp_q.size(), 0);
                    return;
                end
            end
        end
        axis.tvalid = 1'b0;
        axis.tlast  = 1'b0;
        n = 0;
        while (sends == s0) begin
            @(negedge clk);
            n++;
            if (n > 3000) begin
                check("send_timeout", 1'b0, 1'b1);
                abort = 1;
                return;
            end
        end
    endtask

    // scoreboard monitor
    initial begin
        exp_t e;
        int stripe_wins = 0, rd_cnt = 0, val_cnt = 0, last_rd_cyc = 0;
        logic prev_ready = 1'b0, prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                stripe_wins = 0;
                rd_cnt = 0;
                val_cnt = 0;
            end else begin
                if (pe_valid) begin
                    val_cnt++;
                    stripe_wins++;
                    check("tready_low_in_sweep", prev_ready, 1'b0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_window", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("win_s%0d_c%0d", e.stripe, e.col), {r1, r2, r3, r4, r5}, e.win);
                        if (e.exp_cyc >= 0) check("first_window_latency", cyc, e.exp_cyc);
                        if (img_mode == 0 && e.col == 0 && e.stripe == 0) begin
                            check("ramp_s0_row1", r1, 24'h000102);
                            check("ramp_s0_row5", r5, 24'h040506);
                        end
                        if (img_mode == 0 && e.col == 0 && e.stripe == 1)
                            check("ramp_s1_row1", r1, 24'h030405);
                    end
                end
                if (row_done) begin
                    rd_cnt++;
                    check("windows_per_stripe", stripe_wins, WPS);
                    check("row_done_after_last_window", {prev_valid, pe_valid}, 2'b10);
                    check("busy_at_row_done", busy, 1'b1);
                    stripe_wins = 0;
                    last_rd_cyc = cyc;
                end
                if (send_flg) begin
                    check("row_done_count", rd_cnt, NS);
                    check("valid_cycle_count", val_cnt, NS * WPS);
                    check("send_gap", cyc - last_rd_cyc, 9);
                    check("busy_low_at_send", busy, 1'b0);
                    check("err_at_send", err, exp_err);
                    check("queue_drained", exp_q.size(), 0);
                    sends++;
                    rd_cnt = 0;
                    val_cnt = 0;
                end
            end
            prev_ready = axis.tready;
            prev_valid = pe_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        axis.tvalid = 1'b0;
        axis.tdata  = '0;
        axis.tlast  = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;
        @(negedge clk);
        check("tready_after_reset", axis.tready, 1'b1);
        run_image(0, 1'b0, -1, -1, 1'b0);
        if (!abort) run_image(1, 1'b1, -1, -1, 1'b0);
        if (!abort) run_image(0, 1'b1, -1, -1, 1'b0);
        if (!abort) run_image(1, 1'b0, 20, -1, 1'b0);
        if (!abort) run_image(0, 1'b0, -1, -1, 1'b0);
`ifdef FEEDER_TLAST_CHECK_EN
        if (!abort) begin
            run_image(1, 1'b0, -1, 100, 1'b0);
            pulse_reset();
            exp_err = 1'b1;
            run_image(1, 1'b0, -1, -1, 1'b1);
        end
`endif
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
